bit_serial_mac_param: RTL and testbench

Parametrised successor to the fixed 8-bit bit-serial MAC. Multiplies a signed activation by a signed weight, serialising the weight LSB-first with a runtime-selectable weight precision (1..W_W bits). It adds the product into a wide saturating or wrapping accumulator. A valid/ready input handshake and a one-cycle result strobe replace free-running counter sequencing, so the block can sit behind a feeder FIFO in the PE array.

---
 rtl/bit_serial_mac_param.sv | 113 +++++++++++
 tb/tb_bit_serial_mac_param.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_mac_param.sv
// Bit-serial signed MAC: weight shifted LSB-first at runtime precision, product added into a saturating/wrapping accumulator.
// Latency nbits+1 edges from accept to result strobe; in_ready only in IDLE/ACC, so operands are held by the source during RUN.
module bit_serial_mac_param #(
   parameter int A_W    = 8,
   parameter int W_W    = 8,
   parameter int ACC_W  = 24,
   parameter int SAT    = 1,
   parameter int PREC_W = $clog2(W_W) + 1
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [A_W-1:0]         act,
   input  logic [W_W-1:0]         wgt,
   input  logic [PREC_W-1:0]      wbits,
   input  logic                   acc_clr,
   output logic [A_W+W_W-1:0]     product,
   output logic [ACC_W-1:0]       result,
   output logic                   out_valid,
   output logic                   ovf,
   output logic                   busy
);

   localparam int P_W = A_W + W_W;

   typedef enum logic [1:0] {IDLE, RUN, ACC} state_t;

   state_t              state, state_nxt;
   logic [A_W-1:0]      act_q;
   logic [W_W-1:0]      wgt_q;
   logic [PREC_W-1:0]   nbits_q;
   logic [PREC_W-1:0]   cnt;
   logic [PREC_W-1:0]   nbits_in;
   logic                accept;
   logic                last_bit;
   logic                wbit;
   logic [P_W-1:0]      act_ext;
   logic [P_W-1:0]      pp;
   logic [P_W-1:0]      prod_nxt;
   logic [ACC_W-1:0]    acc_base;
   logic [ACC_W:0]      sum;
   logic                sum_ovf;
   logic [ACC_W-1:0]    acc_nxt;

   assign in_ready = (state == IDLE) || (state == ACC);
   assign busy     = (state != IDLE);
   assign accept   = in_valid && in_ready;
   assign nbits_in = (wbits == '0 || wbits > PREC_W'(W_W)) ? PREC_W'(W_W) : wbits;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = RUN;
         RUN:     if (last_bit) state_nxt = ACC;
         ACC:     state_nxt = accept ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The sign bit of the truncated weight carries negative weight, so its partial product is subtracted.
   always_comb begin
      wbit     = |(wgt_q & (W_W'(1) << cnt));
      last_bit = (cnt == nbits_q - PREC_W'(1));
      act_ext  = {{W_W{act_q[A_W-1]}}, act_q};
      pp       = wbit ? (act_ext << cnt) : '0;
      prod_nxt = last_bit ? (product - pp) : (product + pp);
      acc_base = acc_clr ? '0 : result;
      sum      = {acc_base[ACC_W-1], acc_base} + {{(ACC_W+1-P_W){product[P_W-1]}}, product};
      sum_ovf  = sum[ACC_W] ^ sum[ACC_W-1];
      acc_nxt  = sum[ACC_W-1:0];
      if (sum_ovf && SAT != 0)
         acc_nxt = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         act_q     <= '0;
         wgt_q     <= '0;
         nbits_q   <= '0;
         cnt       <= '0;
         product   <= '0;
         result    <= '0;
         out_valid <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         out_valid <= (state == ACC);
         if (state == ACC) begin
            result <= acc_nxt;
            ovf    <= (ovf & ~acc_clr) | sum_ovf;
         end else if (acc_clr) begin
            result <= '0;
            ovf    <= 1'b0;
         end
         if (accept) begin
            act_q   <= act;
            wgt_q   <= wgt;
            nbits_q <= nbits_in;
            cnt     <= '0;
            product <= '0;
         end else if (state == RUN) begin
            product <= prod_nxt;
            cnt     <= cnt + PREC_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_bit_serial_mac_param.sv
// Bench for bit_serial_mac_param: vector table plus scoreboard on the result strobe, with
// back-to-back, mid-run reset, clear-in-ACC and 16-bit saturate/wrap sequences.
module tb_bit_serial_mac_param;

   logic              clk = 1'b0;
   logic              rstn;
   logic              in_valid, in_ready, acc_clr, out_valid, ovf, busy;
   logic signed [7:0] act;
   logic [7:0]        wgt;
   logic [3:0]        wbits;
   logic [15:0]       product;
   logic [23:0]       result;

   logic              v16, c16;
   logic signed [7:0] a16;
   logic [7:0]        w16;
   logic [3:0]        b16;
   logic              rdy_s, ov_s, ovf_s, busy_s, rdy_w, ov_w, ovf_w, busy_w;
   logic [15:0]       prod_s, res_s, prod_w, res_w;

   always #5 clk = ~clk;

   bit_serial_mac_param dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .act(act), .wgt(wgt),
      .wbits(wbits), .acc_clr(acc_clr), .product(product), .result(result),
      .out_valid(out_valid), .ovf(ovf), .busy(busy));

   bit_serial_mac_param #(.ACC_W(16), .SAT(1)) dut_s (
      .clk(clk), .rstn(rstn), .in_valid(v16), .in_ready(rdy_s), .act(a16), .wgt(w16),
      .wbits(b16), .acc_clr(c16), .product(prod_s), .result(res_s),
      .out_valid(ov_s), .ovf(ovf_s), .busy(busy_s));

   bit_serial_mac_param #(.ACC_W(16), .SAT(0)) dut_w (
      .clk(clk), .rstn(rstn), .in_valid(v16), .in_ready(rdy_w), .act(a16), .wgt(w16),
      .wbits(b16), .acc_clr(c16), .product(prod_w), .result(res_w),
      .out_valid(ov_w), .ovf(ovf_w), .busy(busy_w));

   typedef struct {
      logic signed [7:0] a;
      logic [7:0]        w;
      logic [3:0]        b;
      bit                clr;
      longint            ep;
   } vec_t;

   typedef struct {
      longint res;
      bit     o;
   } sb_t;

   vec_t   tbl[11];
   sb_t    q[$];
   int     ov_times[$];
   int     total = 0;
   int     bad = 0;
   int     cyc = 0;
   longint acc_m = 0;
   bit     ovf_m = 0;

   task automatic chk(input string nm, input longint got, input longint exp_v);
      total++;
      if (got !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp_v);
      end
   endtask

   function automatic longint acc_add(input longint acc, input longint p, input int w,
                                      input bit sat, output bit o);
      longint one = 1;
      longint mx  = (one << (w - 1)) - 1;
      longint mn  = -(one << (w - 1));
      longint s   = acc + p;
      o = (s > mx) || (s < mn);
      if (!o) return s;
      if (sat) return (s > mx) ? mx : mn;
      s = s & ((one << w) - 1);
      if (s > mx) s = s - (one << w);
      return s;
   endfunction

   function automatic longint wval(input logic [7:0] w, input logic [3:0] b);
      int     nb = (b == 0 || b > 8) ? 8 : int'(b);
      longint one = 1;
      longint v = longint'(w) & ((one << nb) - 1);
      if (v >= (one << (nb - 1))) v = v - (one << nb);
      return v;
   endfunction

   task automatic push_exp(input longint p, input bit clr);
      bit o;
      sb_t e;
      if (clr) begin
         acc_m = 0;
         ovf_m = 0;
      end
      acc_m = acc_add(acc_m, p, 24, 1'b1, o);
      ovf_m = ovf_m | o;
      e.res = acc_m;
      e.o   = ovf_m;
      q.push_back(e);
   endtask

   task automatic do_op(input logic signed [7:0] a, input logic [7:0] w, input logic [3:0] b,
                        input bit clr, input longint ep, input string nm);
      int nb;
      int bcnt;
      nb = (b == 0 || b > 8) ? 8 : int'(b);
      @(posedge clk); #1;
      chk({nm, "_in_ready"}, longint'(in_ready), 1);
      in_valid = 1'b1; act = a; wgt = w; wbits = b;
      push_exp(ep, clr);
      @(posedge clk); #1;
      in_valid = 1'b0;
      bcnt = int'(busy);
      for (int e = 1; e <= nb; e++) begin
         @(posedge clk); #1;
         bcnt += int'(busy);
      end
      chk({nm, "_product"}, longint'($signed(product)), ep);
      chk({nm, "_busy_cycles"}, bcnt, nb + 1);
      acc_clr = clr;
      @(posedge clk); #1;
      acc_clr = 1'b0;
      chk({nm, "_strobe"}, longint'(out_valid), 1);
      chk({nm, "_busy_end"}, longint'(busy), 0);
      @(posedge clk); #1;
      chk({nm, "_strobe_len"}, longint'(out_valid), 0);
   endtask

   task automatic op16(input longint p, inout longint ms, inout longint mw,
                       inout bit os, inout bit ow, input int k);
      bit o;
      @(posedge clk); #1;
      v16 = 1'b1; a16 = 8'sd127; w16 = 8'd127; b16 = 4'd8;
      @(posedge clk); #1;
      v16 = 1'b0;
      ms = acc_add(ms, p, 16, 1'b1, o); os = os | o;
      mw = acc_add(mw, p, 16, 1'b0, o); ow = ow | o;
      repeat (9) @(posedge clk);
      #1;
      chk($sformatf("sat16_strobe%0d", k), longint'(ov_s), 1);
      chk($sformatf("sat16_result%0d", k), longint'($signed(res_s)), ms);
      chk($sformatf("wrap16_result%0d", k), longint'($signed(res_w)), mw);
      chk($sformatf("sat16_ovf%0d", k), longint'(ovf_s), longint'(os));
      chk($sformatf("wrap16_ovf%0d", k), longint'(ovf_w), longint'(ow));
   endtask

   initial begin
      longint ms, mw;
      bit     os, ow;
      int     n;
      tbl[0]  = '{8'sd5,    8'h03, 4'd8, 1'b0, 15};
      tbl[1]  = '{-8'sd128, 8'h80, 4'd8, 1'b0, 16384};
      tbl[2]  = '{-8'sd128, 8'h7F, 4'd8, 1'b0, -16256};
      tbl[3]  = '{8'sd7,    8'h0F, 4'd4, 1'b0, -7};
      tbl[4]  = '{8'sd3,    8'h01, 4'd1, 1'b0, -3};
      tbl[5]  = '{8'sd7,    8'h0F, 4'd0, 1'b0, 105};
      tbl[6]  = '{-8'sd1,   8'h80, 4'd8, 1'b0, 128};
      tbl[7]  = '{8'sd100,  8'h7F, 4'd8, 1'b1, 12700};
      tbl[8]  = '{8'sd0,    8'h55, 4'd8, 1'b0, 0};
      tbl[9]  = '{-8'sd5,   8'h06, 4'd3, 1'b0, 10};
      tbl[10] = '{8'sd9,    8'hF3, 4'd9, 1'b0, -117};

      rstn = 1'b0; in_valid = 1'b0; acc_clr = 1'b0; act = '0; wgt = '0; wbits = '0;
      v16 = 1'b0; c16 = 1'b0; a16 = '0; w16 = '0; b16 = '0;
      #12;
      chk("rst_in_ready", longint'(in_ready), 1);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_product", longint'(product), 0);
      chk("rst_result", longint'(result), 0);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_ovf", longint'(ovf), 0);
      #10 rstn = 1'b1;

      fork
         begin : monitor
            sb_t e;
            forever begin
               @(negedge clk);
               cyc++;
               if (rstn && out_valid) begin
                  ov_times.push_back(cyc);
                  if (q.size() == 0) begin
                     chk("sb_unexpected_strobe", 1, 0);
                  end else begin
                     e = q.pop_front();
                     chk("sb_result", longint'($signed(result)), e.res);
                     chk("sb_ovf", longint'(ovf), longint'(e.o));
                  end
               end
            end
         end
      join_none

      for (int i = 0; i < 11; i++)
         do_op(tbl[i].a, tbl[i].w, tbl[i].b, tbl[i].clr, tbl[i].ep, $sformatf("vec%0d", i));

      // back-to-back with in_valid held high, 2-bit weights
      ov_times.delete();
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         act      = 8'(i * 3 - 4);
         wgt      = 8'(i + 1);
         wbits    = 4'd2;
         push_exp(longint'(act) * wval(wgt, wbits), 1'b0);
         n = 0;
         @(negedge clk);
         while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
         end
         chk("b2b_ready_timeout", longint'(n >= 20), 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n = 0;
      while (q.size() != 0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("b2b_drain_timeout", longint'(n >= 20), 0);
      chk("b2b_strobes", ov_times.size(), 5);
      for (int i = 1; i < ov_times.size(); i++)
         chk($sformatf("b2b_gap%0d", i), ov_times[i] - ov_times[i-1], 3);

      // asynchronous reset in the middle of RUN
      @(posedge clk); #1;
      in_valid = 1'b1; act = 8'sd9; wgt = 8'd7; wbits = 4'd8;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b0;
      #1;
      chk("midrst_product", longint'(product), 0);
      chk("midrst_result", longint'(result), 0);
      chk("midrst_busy", longint'(busy), 0);
      chk("midrst_in_ready", longint'(in_ready), 1);
      chk("midrst_ovf", longint'(ovf), 0);
      @(posedge clk); #1 rstn = 1'b1;
      q.delete(); acc_m = 0; ovf_m = 0;
      do_op(8'sd2, 8'd2, 4'd8, 1'b0, 4, "post_rst");
      do_op(8'sd96, 8'd1, 4'd8, 1'b0, 96, "to_100");
      do_op(8'sd2, 8'd3, 4'd8, 1'b1, 6, "clr_in_acc");

      // 16-bit accumulators: saturate vs wrap, then clear outside ACC
      ms = 0; mw = 0; os = 0; ow = 0;
      for (int k = 0; k < 4; k++) op16(16129, ms, mw, os, ow, k);
      chk("sat16_final", longint'($signed(res_s)), 32767);
      chk("wrap16_final", longint'($signed(res_w)), -1020);
      @(posedge clk); #1 c16 = 1'b1;
      @(posedge clk); #1 c16 = 1'b0;
      chk("sat16_clr_result", longint'(res_s), 0);
      chk("sat16_clr_ovf", longint'(ovf_s), 0);
      chk("wrap16_clr_result", longint'(res_w), 0);
      chk("wrap16_clr_ovf", longint'(ovf_w), 0);

      repeat (3) @(posedge clk);
      chk("sb_drain", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
